// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, two write ports and the scoreboard set port.
// Writes and sb_set are single-cycle strobes sampled on the rising clk edge; reads are combinational.
interface reg_file_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                we0;
  logic [AW-1:0]       waddr0;
  logic [XLEN-1:0]     wdata0;
  logic                we1;
  logic [AW-1:0]       waddr1;
  logic [XLEN-1:0]     wdata1;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;

  modport master (
    output raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, sb_set, sb_addr,
    input  rdata, rbusy
  );

  modport slave (
    input  raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, sb_set, sb_addr,
    output rdata, rbusy
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with busy scoreboard and a post-reset init sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file_mp #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NRD       = 2,
  parameter int INIT_BASE = 128
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ready,
  output logic [0:0]    fsm_state,
  reg_file_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]       state;
  logic [AW-1:0]    ptr;
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [XLEN-1:0]  init_val;
  logic             wr0_en;
  logic             wr1_en;
  logic             sb_en;

  assign ready     = (state == ST_READY);
  assign fsm_state = state;

  // Writes to register 0 and anything arriving during INIT are dropped here.
  assign wr0_en = ready && bus.we0 && (bus.waddr0 != '0);
  assign wr1_en = ready && bus.we1 && (bus.waddr1 != '0);
  assign sb_en  = ready && bus.sb_set && (bus.sb_addr != '0);

  assign init_val = XLEN'(INIT_BASE) + XLEN'(ptr) - XLEN'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_INIT;
      ptr   <= AW'(1);
    end else if (state == ST_INIT) begin
      ptr <= ptr + AW'(1);
      if (ptr == AW'(NREGS - 1)) state <= ST_READY;
    end
  end

  // Storage is deliberately not reset; the sequencer fills it after reset.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      regs[ptr] <= init_val;
    end else begin
      if (wr0_en) regs[bus.waddr0] <= bus.wdata0;
      if (wr1_en) regs[bus.waddr1] <= bus.wdata1;
    end
  end

  // Clears first, then set, so a same-address set survives a concurrent write.
  always_comb begin
    busy_nxt = busy;
    if (wr0_en) busy_nxt[bus.waddr0] = 1'b0;
    if (wr1_en) busy_nxt[bus.waddr1] = 1'b0;
    if (sb_en)  busy_nxt[bus.sb_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rb;
    bus.rdata = '0;
    bus.rbusy = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = bus.raddr[k*AW +: AW];
      rd = '0;
      rb = 1'b0;
      if (ready && (ra != '0)) begin
        rd = regs[ra];
        rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
        if (wr0_en && (bus.waddr0 == ra)) begin
          rd = bus.wdata0;
          rb = 1'b0;
        end
        if (wr1_en && (bus.waddr1 == ra)) begin
          rd = bus.wdata1;
          rb = 1'b0;
        end
`else
        rd = regs[ra];
`endif
      end
      bus.rdata[k*XLEN +: XLEN] = rd;
      bus.rbusy[k] = rb;
    end
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: init sequence, dual writes, scoreboard, bypass and async reset.
module tb_reg_file_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic       clk;
  logic       rst;
  logic       ready;
  logic [0:0] fsm_state;
  int         checks;
  int         errors;

  reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .INIT_BASE(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .fsm_state (fsm_state),
    .bus       (bus)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.we0 = 1'b0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.we1 = 1'b0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.sb_set = 1'b0; bus.sb_addr = '0;
  endtask

  task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.raddr = {a1, a0};
  endtask

  task automatic wait_ready(input string tag, output int edges);
    edges = 0;
    while (!ready && edges < 100) begin
      tick();
      edges++;
    end
    check(tag, 64'(ready), 64'd1);
  endtask

  function automatic logic [XLEN-1:0] rd0();
    return bus.rdata[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] rd1();
    return bus.rdata[2*XLEN-1:XLEN];
  endfunction

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    idle_inputs();
    set_raddr(5'd0, 5'd0);
    repeat (3) tick();
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_state", 64'(fsm_state), 64'd0);

    // release reset, hammer writes/sb_set during INIT, count edges until ready
    rst = 1'b1;
    bus.we0 = 1'b1; bus.waddr0 = 5'd5; bus.wdata0 = 32'hDEAD;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd6;
    set_raddr(5'd5, 5'd1);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
      if (n == 10) begin
        check("init_rdata0_zero", 64'(rd0()), 64'd0);
        check("init_rdata1_zero", 64'(rd1()), 64'd0);
        check("init_rbusy_zero", 64'(bus.rbusy), 64'd0);
      end
    end
    idle_inputs();
    check("init_edge_count", 64'(n), 64'd31);
    check("init_ready", 64'(ready), 64'd1);
    set_raddr(5'd1, 5'd31);
    #1;
    check("init_reg1", 64'(rd0()), 64'd128);
    check("init_reg31", 64'(rd1()), 64'd158);
    set_raddr(5'd5, 5'd6);
    #1;
    check("init_reg5_not_dead", 64'(rd0()), 64'd132);
    check("init_sb_ignored", 64'(bus.rbusy), 64'd0);
    set_raddr(5'd0, 5'd12);
    #1;
    check("reg0_reads_zero", 64'(rd0()), 64'd0);
    check("init_reg12", 64'(rd1()), 64'd139);

    // dual-write conflict: port 1 wins
    tick();
    bus.we0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'h1111;
    bus.we1 = 1'b1; bus.waddr1 = 5'd7; bus.wdata1 = 32'h2222;
    tick();
    idle_inputs();
    set_raddr(5'd7, 5'd7);
    #1;
    check("conflict_port1_wins", 64'(rd0()), 64'h2222);

    // independent writes on both ports
    bus.we0 = 1'b1; bus.waddr0 = 5'd8;  bus.wdata0 = 32'h1234;
    bus.we1 = 1'b1; bus.waddr1 = 5'd10; bus.wdata1 = 32'h5678;
    tick();
    idle_inputs();
    set_raddr(5'd8, 5'd10);
    #1;
    check("dual_write_p0", 64'(rd0()), 64'h1234);
    check("dual_write_p1", 64'(rd1()), 64'h5678);

    // writes and sb_set to register 0 are ignored
    bus.we0 = 1'b1; bus.waddr0 = 5'd0; bus.wdata0 = 32'hFFFF;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd0;
    tick();
    idle_inputs();
    set_raddr(5'd0, 5'd0);
    #1;
    check("reg0_write_ignored", 64'(rd0()), 64'd0);
    check("reg0_never_busy", 64'(bus.rbusy), 64'd0);

    // scoreboard set
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    tick();
    idle_inputs();
    set_raddr(5'd9, 5'd9);
    #1;
    check("sb_set_busy", 64'(bus.rbusy), 64'b11);

    // set and clear same address: set wins; write still lands
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    bus.we1 = 1'b1; bus.waddr1 = 5'd9; bus.wdata1 = 32'h99;
    tick();
    idle_inputs();
    #1;
    check("sb_set_wins", 64'(bus.rbusy[0]), 64'd1);
    check("sb_write_while_busy", 64'(rd0()), 64'h99);

    // clear by write alone
    bus.we0 = 1'b1; bus.waddr0 = 5'd9; bus.wdata0 = 32'h9A;
    tick();
    idle_inputs();
    #1;
    check("sb_clear_by_write", 64'(bus.rbusy[0]), 64'd0);

    // set one address while clearing another
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    tick();
    bus.sb_set = 1'b1; bus.sb_addr = 5'd11;
    bus.we0 = 1'b1; bus.waddr0 = 5'd9; bus.wdata0 = 32'h9B;
    tick();
    idle_inputs();
    set_raddr(5'd9, 5'd11);
    #1;
    check("sb_clear_other", 64'(bus.rbusy), 64'b10);

    // bypass / write-then-read timing
    set_raddr(5'd12, 5'd13);
    bus.we0 = 1'b1; bus.waddr0 = 5'd12; bus.wdata0 = 32'hCAFE;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", 64'(rd0()), 64'hCAFE);
`else
    check("no_bypass_old_value", 64'(rd0()), 64'd139);
`endif
    tick();
    idle_inputs();
    #1;
    check("write_visible_next", 64'(rd0()), 64'hCAFE);

    bus.we0 = 1'b1; bus.waddr0 = 5'd13; bus.wdata0 = 32'h1;
    bus.we1 = 1'b1; bus.waddr1 = 5'd13; bus.wdata1 = 32'h2;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_port1_prio", 64'(rd1()), 64'h2);
`else
    check("no_bypass_reg13", 64'(rd1()), 64'd140);
`endif
    tick();
    idle_inputs();

    // reset mid-operation
    bus.we0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'hAAAA;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd4;
    tick();
    idle_inputs();
    set_raddr(5'd3, 5'd4);
    #1;
    check("pre_reset_reg3", 64'(rd0()), 64'hAAAA);
    check("pre_reset_busy4", 64'(bus.rbusy[1]), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_ready", 64'(ready), 64'd0);
    check("async_reset_state", 64'(fsm_state), 64'd0);
    check("async_reset_busy", 64'(dut.busy), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    wait_ready("reinit_ready", n);
    check("reinit_edge_count", 64'(n), 64'd31);
    #1;
    check("reinit_reg3", 64'(rd0()), 64'd130);
    check("reinit_busy4", 64'(bus.rbusy[1]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file with a scoreboard, for the single-cycle core and its planned multi-cycle extensions.
- Provides NRD combinational read ports and two synchronous write ports (ALU and load/long-latency writeback).
- Holds a per-register busy scoreboard.
- After reset, a sequencer loads the power-on value pattern; the block reports ready only when loading is complete.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of registers (power of 2, >=4); AW = log2(NREGS)
NRD, 2, number of read ports (>=1)
INIT_BASE, 128, register i (i>=1) initialises to INIT_BASE + i - 1, truncated to XLEN

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ready  out  1  high when the init sequence is done and the file is usable
raddr  in  NRD*AW  read addresses; port k uses slice [k*AW +: AW]
rdata  out  NRD*XLEN  read data; port k uses slice [k*XLEN +: XLEN]
rbusy  out  NRD  scoreboard busy bit for each read port's address
we0  in  1  write enable, port 0
waddr0  in  AW  write address, port 0
wdata0  in  XLEN  write data, port 0
we1  in  1  write enable, port 1
waddr1  in  AW  write address, port 1
wdata1  in  XLEN  write data, port 1
sb_set  in  1  mark register busy (producer issued)
sb_addr  in  AW  register to mark busy

Behaviour:
- Reset (rst=0, async):
  - state=INIT, init pointer=1, ready=0, all busy bits=0.
  - Storage contents are not reset.
  - Reset asserted mid-INIT or mid-READY restarts the init sequence from pointer 1.
- FSM, INIT state:
  - Each clk edge writes INIT_BASE+ptr-1 to reg[ptr], then ptr++.
  - When ptr==NREGS-1 is written, go to READY.
  - INIT lasts NREGS-1 cycles after rst deasserts; ready rises on the edge that writes the last register.
- During INIT:
  - we0, we1 and sb_set are ignored.
  - rdata = 0 and rbusy = 0 on all ports.
- FSM, READY state: stays READY until reset.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and sb_set to address 0 are ignored.
- Reads:
  - Combinational, zero latency: rdata[k] = reg[raddr[k]]; rbusy[k] = busy[raddr[k]].
- Writes:
  - Occur on the rising clk edge when weN=1 and waddrN!=0; the new value is visible to reads the following cycle (see optional feature).
  - we0 and we1 to the same address in the same cycle: port 1 wins.
- Scoreboard:
  - sb_set sets busy[sb_addr] on the edge.
  - Any write (either port) clears busy[waddr] on the edge.
  - Set and clear of the same address in the same cycle: set wins, so the bit stays 1.
  - Set of one address and clear of another in the same cycle: both take effect.
- Writes are accepted regardless of busy state; the scoreboard is advisory to the issue logic.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined (READY state only):
  - A read port whose raddr matches an active write this cycle (address nonzero) returns that write's wdata combinationally; port 1 data has priority over port 0.
  - rbusy for that port reads 0.
- When undefined:
  - Reads return the stored value; the written data appears one cycle later.
  - rbusy reflects the registered busy bit.

Test Plan:
- Reset and init:
  - Stimulus: rst low for 3 cycles, then high; count cycles; then read raddr=1 and raddr=31.
  - Required: ready stays 0 for exactly 31 edges, then goes to 1; rdata=128 (0x80) and 158 (0x9E).
  - Required: during INIT, rdata=0 even with we0=1, waddr0=5, wdata0=0xDEAD; after ready, reg5 = 132.
- Dual-write conflict:
  - Stimulus: we0=1, waddr0=7, wdata0=0x1111; we1=1, waddr1=7, wdata1=0x2222.
  - Required: next cycle reg7 reads 0x2222.
  - Stimulus: a write of 0xFFFF to reg 0.
  - Required: reads as 0.
- Scoreboard:
  - Stimulus: sb_set on reg 9.
  - Required: rbusy=1 for a port reading 9 on the next cycle.
  - Stimulus: same cycle sb_set(9) and we1 to reg 9.
  - Required: busy remains 1.
  - Stimulus: we0 to reg 9 alone.
  - Required: busy=0 next cycle.
- Bypass:
  - Stimulus: raddr0=12 while we0=1, waddr0=12, wdata0=0xCAFE.
  - Required with REGFILE_BYPASS_EN: rdata0=0xCAFE in the same cycle.
  - Required without it: rdata0=139 (old value), then 0xCAFE the next cycle.
- Reset mid-operation:
  - Stimulus: write 0xAAAA to reg 3, then assert rst mid-cycle (async), then release.
  - Required: ready drops to 0 immediately and busy bits clear.
  - Required: after re-init, reg3 = 130.
